svi_logic_responder: RTL

//  Responder end of the SVI logic-operand channel. Initiator modules drive x/y

---
 rtl/svi_logic_responder.sv | 92 +++++++++
 1 files changed

// File: rtl/svi_logic_responder.sv
// Responder end of the SVI logic-operand channel: computes z = f(x,y,op) per request
// and returns tagged results in acceptance order through a small response FIFO.
module svi_logic_responder #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned TAG_W = 2,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 4
) (
  input  logic             i_sclk,
  input  logic             i_arst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [WIDTH-1:0] i_req_x,
  input  logic [WIDTH-1:0] i_req_y,
  input  logic [1:0]       i_req_op,
  input  logic [TAG_W-1:0] i_req_tag,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_z,
  output logic [TAG_W-1:0] o_rsp_tag,
  output logic [CNT_W-1:0] o_rsp_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } op_e;

  logic [AW:0]        wptr;
  logic [AW:0]        rptr;
  logic [WIDTH-1:0]   mem_z   [DEPTH];
  logic [TAG_W-1:0]   mem_tag [DEPTH];
  logic [WIDTH-1:0]   f_z;
  logic               empty;
  logic               full;
  logic               push;
  logic               pop;
  logic [CNT_W-1:0]   cnt;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  assign o_req_ready = ~full;
  assign o_rsp_valid = ~empty;
  assign push        = i_req_valid & o_req_ready;
  assign pop         = o_rsp_valid & i_rsp_ready;

  always_comb begin
    f_z = '0;
    case (op_e'(i_req_op))
      OP_AND:  f_z = i_req_x & i_req_y;
      OP_OR:   f_z = i_req_x | i_req_y;
      OP_XOR:  f_z = i_req_x ^ i_req_y;
      OP_NAND: f_z = ~(i_req_x & i_req_y);
      default: f_z = '0;
    endcase
  end

  always_ff @(posedge i_sclk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge i_sclk) begin
    if (push) begin
      mem_z[wptr[AW-1:0]]   <= f_z;
      mem_tag[wptr[AW-1:0]] <= i_req_tag;
    end
  end

  always_ff @(posedge i_sclk or negedge i_arst_n) begin
    if (!i_arst_n)
      cnt <= '0;
    else if (pop && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

  assign o_rsp_count = cnt;
  assign o_rsp_z     = empty ? '0 : mem_z[rptr[AW-1:0]];
  assign o_rsp_tag   = empty ? '0 : mem_tag[rptr[AW-1:0]];

endmodule
